// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter state encoding and the round-robin pointer increment.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB,
    ST_LOCK,
    ST_CLR,
    ST_DONE
  } arb_state_e;

  function automatic int unsigned rr_next(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational round-robin priority select.
// Rotates the request vector by the pointer and picks the first set bit.
module rr_prio_select #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [N-1:0] rot;
  int           sel;
  int           sum;

  always_comb begin
    rot   = N'({req_i, req_i} >> ptr_i);
    sel   = 0;
    any_o = 1'b0;
    // Downward scan so the lowest rotated index wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sel   = i;
        any_o = 1'b1;
      end
    end
    sum = int'(ptr_i) + sel;
    if (sum >= N) sum = sum - N;
    gnt_idx_o = IW'(sum);
    gnt_oh_o  = any_o ? (N'(1) << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// Packet-atomic round-robin arbiter for a shared FIFO write port.
// Also sequences a one-cycle FIFO clear on a flush request.
module fifo_wr_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int PKT_LOCK   = 1,
  localparam int IW         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            s_valid,
  input  logic [NUM_REQ-1:0]            s_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  output logic [NUM_REQ-1:0]            s_ready,
  input  logic                          i_flush,
  output logic                          o_flush_done,
  output logic [IW-1:0]                 o_grant_id,
  output logic                          o_busy,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic                          fifo_clr
);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     lock_q, lock_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic [NUM_REQ-1:0] arb_oh;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_ok;
  logic              acc;
  logic              last;
  logic              ends;

  rr_prio_select #(
    .N(NUM_REQ)
  ) u_sel (
    .req_i    (s_valid),
    .ptr_i    (ptr_q),
    .gnt_oh_o (arb_oh),
    .gnt_idx_o(arb_idx),
    .any_o    (arb_any)
  );

  always_comb begin
    gnt_idx = arb_idx;
    gnt_oh  = arb_oh;
    gnt_ok  = 1'b0;
    unique case (state_q)
      ST_ARB:  gnt_ok = arb_any && !i_flush;
      ST_LOCK: begin
        gnt_idx = lock_q;
        gnt_oh  = NUM_REQ'(1) << lock_q;
        gnt_ok  = 1'b1;
      end
      default: gnt_ok = 1'b0;
    endcase
    // Gating with rst_n keeps s_ready low while reset is held.
    s_ready      = (gnt_ok && rst_n && !fifo_full) ? gnt_oh : '0;
    acc          = |(s_valid & s_ready);
    last         = s_last[gnt_idx];
    ends         = acc && ((PKT_LOCK == 0) || last);
    fifo_wr_en   = acc;
    fifo_wr_data = s_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ends ? IW'(rr_next(32'(gnt_idx), NUM_REQ)) : ptr_q;
    lock_d  = acc ? gnt_idx : lock_q;
    gid_d   = acc ? gnt_idx : gid_q;
    unique case (state_q)
      ST_ARB: begin
        if (i_flush) state_d = ST_CLR;
        else if (acc && !ends) state_d = ST_LOCK;
      end
      ST_LOCK: if (ends) state_d = ST_ARB;
      ST_CLR:  state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_ARB;
        ptr_d   = '0;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      lock_q  <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      gid_q   <= gid_d;
    end
  end

  assign fifo_clr     = (state_q == ST_CLR);
  assign o_flush_done = (state_q == ST_DONE);
  assign o_busy       = (state_q != ST_ARB);
  assign o_grant_id   = gid_q;

endmodule
